// File: rtl/awgn_iq_channel_if.sv
// Sample-stream interface for awgn_iq_channel: upstream I/Q samples with per-sample
// controls, downstream noisy I/Q samples, and the clip counter.
interface awgn_iq_channel_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in_real;
  logic signed [DATA_W-1:0] x_in_imag;
  logic        [3:0]        snr_db;
  logic                     noise_en;
  logic                     reseed;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y_out_real;
  logic signed [DATA_W-1:0] y_out_imag;
  logic        [15:0]       sat_count;

  modport master (
    output in_valid, x_in_real, x_in_imag, snr_db, noise_en, reseed, out_ready,
    input  in_ready, out_valid, y_out_real, y_out_imag, sat_count
  );

  modport slave (
    input  in_valid, x_in_real, x_in_imag, snr_db, noise_en, reseed, out_ready,
    output in_ready, out_valid, y_out_real, y_out_imag, sat_count
  );
endinterface

// File: rtl/awgn_iq_channel.sv
// Complex AWGN channel: per-rail sum of four LFSR uniforms, SNR-scaled, added to I/Q and
// saturated, in a 3-stage valid/ready pipeline. Define AWGN_SAT_CNT_EN to build the clip counter.
module awgn_iq_channel #(
  parameter int          DATA_W      = 8,
  parameter int          NOISE_SHIFT = 2,
  parameter logic [15:0] SEED_BASE   = 16'hACE1,
  parameter logic [15:0] LFSR_POLY   = 16'hB400
) (
  input logic              clk,
  input logic              reset,
  awgn_iq_channel_if.slave bus
);

  localparam int SUM_W   = 10;
  localparam int PROD_W  = SUM_W + 10;
  localparam int NOISE_W = 10;
  // Adder width that can never wrap for any DATA_W, so saturation sees the true sum.
  localparam int ACC_W   = ((DATA_W + 3) > (NOISE_W + 2)) ? (DATA_W + 3) : (NOISE_W + 2);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 <<< (DATA_W - 1)));

  function automatic logic [15:0] seed_of(input int k);
    logic [15:0] s;
    s = SEED_BASE + 16'(k) * 16'h1111;
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic signed [7:0] uniform(input logic [15:0] s);
    return {~s[7], s[6:0]};
  endfunction

  // round(256 * 10^(-k/20)) for k = 0..15 dB.
  function automatic logic [8:0] sigma_of(input logic [3:0] k);
    case (k)
      4'd0:    return 9'd256;
      4'd1:    return 9'd228;
      4'd2:    return 9'd203;
      4'd3:    return 9'd181;
      4'd4:    return 9'd162;
      4'd5:    return 9'd144;
      4'd6:    return 9'd128;
      4'd7:    return 9'd114;
      4'd8:    return 9'd102;
      4'd9:    return 9'd91;
      4'd10:   return 9'd81;
      4'd11:   return 9'd72;
      4'd12:   return 9'd64;
      4'd13:   return 9'd57;
      4'd14:   return 9'd51;
      default: return 9'd46;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > Y_MAX)      return DATA_W'(Y_MAX);
    else if (v < Y_MIN) return DATA_W'(Y_MIN);
    else                return DATA_W'(v);
  endfunction

  // Flow control: every stage advances together whenever the output register can move.
  logic adv;
  logic accept;
  logic out_valid_q;

  assign adv          = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & adv;
  assign bus.in_ready = adv;

  // LFSR bank: 0..3 feed I, 4..7 feed Q.
  logic [15:0] lfsr_q [8];

  // NOTE: the seed bank is a handful of flops, not a RAM, and must reset because the
  // noise sequence after reset is defined by it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) lfsr_q[k] <= seed_of(k);
    end else if (bus.reseed) begin
      for (int k = 0; k < 8; k++) lfsr_q[k] <= seed_of(k);
    end else if (accept) begin
      for (int k = 0; k < 8; k++) lfsr_q[k] <= lfsr_step(lfsr_q[k]);
    end
  end

  logic signed [SUM_W-1:0] sum_i;
  logic signed [SUM_W-1:0] sum_q;

  // NOTE: blocking assignments here make the running sum chain within one evaluation;
  // assigning a default first keeps the block free of inferred latches.
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < 4; k++) begin
      sum_i = sum_i + SUM_W'(uniform(lfsr_q[k]));
      sum_q = sum_q + SUM_W'(uniform(lfsr_q[k + 4]));
    end
  end

  // Stage 1: capture the sample, its controls and the raw noise sums.
  logic                     v1;
  logic signed [DATA_W-1:0] x1_r, x1_i;
  logic        [3:0]        snr1;
  logic                     nen1;
  logic signed [SUM_W-1:0]  sum1_i, sum1_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      x1_r   <= '0;
      x1_i   <= '0;
      snr1   <= '0;
      nen1   <= 1'b0;
      sum1_i <= '0;
      sum1_q <= '0;
    end else if (adv) begin
      v1     <= bus.in_valid;
      x1_r   <= bus.x_in_real;
      x1_i   <= bus.x_in_imag;
      snr1   <= bus.snr_db;
      nen1   <= bus.noise_en;
      sum1_i <= sum_i;
      sum1_q <= sum_q;
    end
  end

  // Stage 2: scale by the SNR gain; the arithmetic shift floors toward minus infinity.
  logic        [8:0]         g;
  logic signed [PROD_W-1:0]  prod_i, prod_q;
  logic signed [NOISE_W-1:0] noise_i, noise_q;

  always_comb begin
    g       = sigma_of(snr1);
    prod_i  = PROD_W'(sum1_i) * PROD_W'($signed({1'b0, g}));
    prod_q  = PROD_W'(sum1_q) * PROD_W'($signed({1'b0, g}));
    noise_i = '0;
    noise_q = '0;
    if (nen1) begin
      noise_i = NOISE_W'(prod_i >>> (8 + NOISE_SHIFT));
      noise_q = NOISE_W'(prod_q >>> (8 + NOISE_SHIFT));
    end
  end

  logic                      v2;
  logic signed [DATA_W-1:0]  x2_r, x2_i;
  logic signed [NOISE_W-1:0] n2_i, n2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2   <= 1'b0;
      x2_r <= '0;
      x2_i <= '0;
      n2_i <= '0;
      n2_q <= '0;
    end else if (adv) begin
      v2   <= v1;
      x2_r <= x1_r;
      x2_i <= x1_i;
      n2_i <= noise_i;
      n2_q <= noise_q;
    end
  end

  // Stage 3: add and saturate into the output register.
  logic signed [ACC_W-1:0] acc_r, acc_i;

  always_comb begin
    acc_r = ACC_W'(x2_r) + ACC_W'(n2_i);
    acc_i = ACC_W'(x2_i) + ACC_W'(n2_q);
  end

  logic signed [DATA_W-1:0] y_r_q, y_i_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_r_q       <= '0;
      y_i_q       <= '0;
    end else if (adv) begin
      out_valid_q <= v2;
      y_r_q       <= saturate(acc_r);
      y_i_q       <= saturate(acc_i);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.y_out_real = y_r_q;
  assign bus.y_out_imag = y_i_q;

`ifdef AWGN_SAT_CNT_EN
  // A sample counts as clipped if either rail hit a rail limit.
  logic        clip3;
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip3 <= 1'b0;
    end else if (adv) begin
      clip3 <= (acc_r > Y_MAX) | (acc_r < Y_MIN) | (acc_i > Y_MAX) | (acc_i < Y_MIN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && clip3 && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign bus.sat_count = sat_cnt_q;
`else
  assign bus.sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_awgn_iq_channel.sv
// Self-checking bench for awgn_iq_channel: table-driven pass-through, noise statistics,
// stall, randomized traffic against a sample-level reference model, reseed and async reset.
module tb_awgn_iq_channel;

  localparam int          DATA_W    = 8;
  localparam int          NS        = 2;
  localparam logic [15:0] SEED_BASE = 16'hACE1;
  localparam logic [15:0] POLY      = 16'hB400;
  localparam int          Y_LO      = -(1 << (DATA_W - 1));
  localparam int          Y_HI      = (1 << (DATA_W - 1)) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  awgn_iq_channel_if #(.DATA_W(DATA_W)) bus ();

  awgn_iq_channel #(
    .DATA_W(DATA_W), .NOISE_SHIFT(NS), .SEED_BASE(SEED_BASE), .LFSR_POLY(POLY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input real actual, input real lo, input real hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("FAIL %s: got %f, expected within [%f, %f]", name, actual, lo, hi);
    end
  endtask

  // ---------------- reference model: one expected output per accepted sample
  typedef struct { int yr; int yi; bit clip; } exp_t;

  int          sigma [16] = '{256, 228, 203, 181, 162, 144, 128, 114, 102, 91, 81, 72, 64, 57, 51, 46};
  logic [15:0] ms [8];
  exp_t        exp_q [$];
  int          model_sat;

  function automatic logic [15:0] seed_val(input int k);
    int s;
    s = (int'(SEED_BASE) + k * 4369) % 65536;
    return (s == 0) ? 16'd1 : 16'(s);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s[0]) return (s >> 1) ^ POLY;
    return s >> 1;
  endfunction

  function automatic int unif(input logic [15:0] s);
    return int'(s[7:0]) - 128;
  endfunction

  function automatic int clamp(input int v);
    if (v > Y_HI) return Y_HI;
    if (v < Y_LO) return Y_LO;
    return v;
  endfunction

  task automatic model_seed();
    for (int k = 0; k < 8; k++) ms[k] = seed_val(k);
  endtask

  task automatic model_cycle(input bit acc, input int xr, input int xi, input int snr,
                             input bit nen, input bit rs);
    exp_t e;
    int si, sq, ni, nq;
    if (acc) begin
      si = 0;
      sq = 0;
      for (int k = 0; k < 4; k++) begin
        si += unif(ms[k]);
        sq += unif(ms[k + 4]);
      end
      ni     = nen ? ((si * sigma[snr]) >>> (8 + NS)) : 0;
      nq     = nen ? ((sq * sigma[snr]) >>> (8 + NS)) : 0;
      e.yr   = clamp(xr + ni);
      e.yi   = clamp(xi + nq);
      e.clip = (e.yr != xr + ni) || (e.yi != xi + nq);
      exp_q.push_back(e);
    end
    if (rs) model_seed();
    else if (acc) for (int k = 0; k < 8; k++) ms[k] = lfsr_next(ms[k]);
  endtask

  // ---------------- cycle driver + scoreboard
  bit last_acc, last_ofire, last_ovalid, last_iready;
  int last_yr, last_yi;
  int cap_r [$], cap_i [$], capx_r [$], capx_i [$];

  task automatic cycle(input bit v, input int xr, input int xi, input int snr,
                       input bit nen, input bit rs, input bit ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.x_in_real = DATA_W'(xr);
    bus.x_in_imag = DATA_W'(xi);
    bus.snr_db    = 4'(snr);
    bus.noise_en  = nen;
    bus.reseed    = rs;
    bus.out_ready = ordy;
    #1;
    last_iready = bus.in_ready;
    last_ovalid = bus.out_valid;
    last_acc    = v && bus.in_ready;
    last_ofire  = bus.out_valid && ordy;
    last_yr     = int'(bus.y_out_real);
    last_yi     = int'(bus.y_out_imag);
    if (last_ofire) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_output: got y=(%0d,%0d), expected no output", last_yr, last_yi);
      end else begin
        e = exp_q.pop_front();
        check("y_real", last_yr, e.yr);
        check("y_imag", last_yi, e.yi);
        cap_r.push_back(last_yr);
        cap_i.push_back(last_yi);
        capx_r.push_back(e.yr);
        capx_i.push_back(e.yi);
        if (e.clip && model_sat < 65535) model_sat++;
      end
    end
    model_cycle(last_acc, xr, xi, snr, nen, rs);
  endtask

  task automatic drain();
    for (int g = 0; g < 20 && exp_q.size() > 0; g++) cycle(0, 0, 0, 0, 0, 0, 1);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clear_caps();
    cap_r.delete(); cap_i.delete(); capx_r.delete(); capx_i.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.reseed   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_seed();
    exp_q.delete();
    model_sat = 0;
  endtask

  task automatic check_sat_count(input string name);
`ifdef AWGN_SAT_CNT_EN
    check(name, int'(bus.sat_count), model_sat);
`else
    check(name, int'(bus.sat_count), 0);
`endif
  endtask

  task automatic noise_stats(input string tag, input int snr, input real exp_std);
    real sr, si, ssr, ssi, n, mr, mi, sdr, sdi;
    clear_caps();
    for (int i = 0; i < 8192; i++) cycle(1, 0, 0, snr, 1, 0, 1);
    drain();
    sr = 0.0; si = 0.0; ssr = 0.0; ssi = 0.0;
    foreach (cap_r[i]) begin
      sr  += real'(cap_r[i]);
      si  += real'(cap_i[i]);
      ssr += real'(cap_r[i]) * real'(cap_r[i]);
      ssi += real'(cap_i[i]) * real'(cap_i[i]);
    end
    n   = real'(cap_r.size() > 0 ? cap_r.size() : 1);
    mr  = sr / n;
    mi  = si / n;
    sdr = $sqrt(ssr / n - mr * mr);
    sdi = $sqrt(ssi / n - mi * mi);
    check({tag, "_count"}, cap_r.size(), 8192);
    check_range({tag, "_mean_i"}, mr, -2.0, 2.0);
    check_range({tag, "_mean_q"}, mi, -2.0, 2.0);
    check_range({tag, "_std_i"}, sdr, 0.95 * exp_std, 1.05 * exp_std);
    check_range({tag, "_std_q"}, sdi, 0.95 * exp_std, 1.05 * exp_std);
  endtask

  typedef struct { int xr; int xi; int exp_r; int exp_i; } vec_t;
  vec_t tbl [100];
  int   rx [50], ri [50], ar [50], ai [50];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_acc, first_out, last_out, oi, held_r, held_i;

    // Pass-through vectors: noise disabled means y must equal x exactly.
    for (int i = 0; i < 100; i++) begin
      tbl[i].xr    = -128 + i;
      tbl[i].xi    = 127 - 2 * i;
      tbl[i].exp_r = -128 + i;
      tbl[i].exp_i = 127 - 2 * i;
    end

    bus.in_valid = 0; bus.x_in_real = '0; bus.x_in_imag = '0; bus.snr_db = '0;
    bus.noise_en = 0; bus.reseed = 0; bus.out_ready = 1;
    reset = 1'b1;
    model_seed();
    model_sat = 0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_y_real", int'(bus.y_out_real), 0);
    check("rst_y_imag", int'(bus.y_out_imag), 0);
    check("rst_sat_count", int'(bus.sat_count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven pass-through ramp with latency and gap checks.
    first_acc = -1; first_out = -1; last_out = -1; oi = 0;
    for (int it = 0; it < 106; it++) begin
      if (it < 100) cycle(1, tbl[it].xr, tbl[it].xi, 0, 0, 0, 1);
      else          cycle(0, 0, 0, 0, 0, 0, 1);
      if (last_acc && first_acc < 0) first_acc = it;
      if (last_ofire && oi < 100) begin
        if (first_out < 0) begin
          first_out = it;
          check("latency", first_out - first_acc, 3);
        end
        last_out = it;
        check("pt_real", last_yr, tbl[oi].exp_r);
        check("pt_imag", last_yi, tbl[oi].exp_i);
        oi++;
      end
    end
    check("pt_count", oi, 100);
    check("pt_no_gaps", last_out - first_out + 1, 100);
    drain();

    // Noise statistics at x=0 (y is the noise itself, no clipping with this shift).
    noise_stats("snr0", 0, 147.8 * 256.0 / 256.0 / real'(1 << NS));
    noise_stats("snr6", 6, 147.8 * 128.0 / 256.0 / real'(1 << NS));

    // Backpressure: out_ready low for 10 cycles mid-stream, in_valid held high.
    held_r = 0; held_i = 0;
    for (int it = 0; it < 60; it++) begin
      cycle(1, it * 3 - 90, int'($urandom_range(255)) - 128, 4, 1, 0, !(it >= 20 && it < 30));
      if (it == 20) begin
        held_r = last_yr;
        held_i = last_yi;
      end
      if (it >= 20 && it < 30) begin
        check("stall_out_valid", int'(last_ovalid), 1);
        check("stall_in_ready", int'(last_iready), 0);
        check("stall_hold_real", last_yr, held_r);
        check("stall_hold_imag", last_yi, held_i);
      end
    end
    drain();

    // Randomized traffic with random backpressure, controls and occasional reseeds.
    for (int it = 0; it < 3000; it++) begin
      cycle(($urandom % 5) != 0, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
            int'($urandom % 16), ($urandom % 4) != 0, ($urandom % 97) == 0, ($urandom % 4) != 0);
    end
    drain();
    check_sat_count("rand_sat_count");

    // Saturation at the rails.
    do_reset();
    for (int i = 0; i < 1000; i++) cycle(1, 127, -128, 0, 1, 0, 1);
    drain();
    check_sat_count("rail_sat_count");

    // Reseed: the second 50 samples repeat the first 50 after reset.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      rx[i] = int'($urandom_range(255)) - 128;
      ri[i] = int'($urandom_range(255)) - 128;
    end
    clear_caps();
    for (int i = 0; i < 50; i++) cycle(1, rx[i], ri[i], 2, 1, 0, 1);
    drain();
    for (int i = 0; i < 50; i++) begin
      ar[i] = (i < capx_r.size()) ? capx_r[i] : 0;
      ai[i] = (i < capx_i.size()) ? capx_i[i] : 0;
    end
    cycle(0, 0, 0, 2, 1, 1, 1);
    clear_caps();
    for (int i = 0; i < 50; i++) cycle(1, rx[i], ri[i], 2, 1, 0, 1);
    drain();
    check("reseed_count", cap_r.size(), 50);
    for (int i = 0; i < cap_r.size() && i < 50; i++) begin
      check("reseed_repeat_real", cap_r[i], ar[i]);
      check("reseed_repeat_imag", cap_i[i], ai[i]);
    end

    // Async reset with three samples in flight and the first one waiting at the output.
    cycle(1, rx[0], ri[0], 2, 1, 0, 1);
    cycle(1, rx[1], ri[1], 2, 1, 0, 1);
    cycle(1, rx[2], ri[2], 2, 1, 0, 1);
    cycle(0, 0, 0, 2, 1, 0, 0);
    check("pre_reset_out_valid", int'(last_ovalid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", int'(bus.out_valid), 0);
    check("async_y_real", int'(bus.y_out_real), 0);
    check("async_y_imag", int'(bus.y_out_imag), 0);
    check("async_sat_count", int'(bus.sat_count), 0);
    exp_q.delete();
    model_seed();
    model_sat = 0;
    #3;
    reset = 1'b0;
    clear_caps();
    cycle(1, rx[0], ri[0], 2, 1, 0, 1);
    drain();
    check("post_reset_count", cap_r.size(), 1);
    if (cap_r.size() > 0) begin
      check("post_reset_first_real", cap_r[0], ar[0]);
      check("post_reset_first_imag", cap_i[0], ai[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
